// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: load/store -> valid/ready request, waits for the response, extends load data.
// Optional build macro MEM_MISALIGN_CHK_EN rejects misaligned H/W accesses instead of force-aligning them.

module mau_store_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] sz,       // 0 byte, 1 half, 2 word
  input  logic [1:0] addr_lo,
  input  logic [7:0] byte_b,
  input  logic [7:0] byte_h,
  input  logic [7:0] byte_w,
  output logic       strb,
  output logic [7:0] wdata
);
  localparam logic [1:0] IDX = 2'(LANE);

  always_comb begin
    strb  = 1'b1;
    wdata = byte_w;
    case (sz)
      2'd0: begin
        strb  = (addr_lo == IDX);
        wdata = byte_b;
      end
      2'd1: begin
        strb  = (addr_lo[1] == IDX[1]);
        wdata = byte_h;
      end
      default: ;
    endcase
  end
endmodule

module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              MEM_valid,
  input  logic              MEM_mem_rd,
  input  logic              MEM_mem_wr,
  input  logic [2:0]        MEM_funct3,
  input  logic [ADDR_W-1:0] MEM_ALU_out,
  input  logic [DATA_W-1:0] MEM_rs2_data,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_we,
  output logic [ADDR_W-1:0] dm_req_addr,
  output logic [3:0]        dm_req_wstrb,
  output logic [DATA_W-1:0] dm_req_wdata,
  input  logic              dm_rsp_valid,
  input  logic [DATA_W-1:0] dm_rsp_rdata,
  output logic [DATA_W-1:0] DM_data,
  output logic              mem_stall,
  output logic              mem_misalign
);
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t      state;
  req_t        req;
  logic        req_vld;
  logic        busy;
  logic        access;
  logic        misalign_hit;
  logic [1:0]  req_sz;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [DATA_W-1:0] ld_ext;

  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 2'd0;
      3'b001, 3'b101: return 2'd1;
      default:        return 2'd2;
    endcase
  endfunction

  assign access = MEM_valid & (MEM_mem_rd | MEM_mem_wr);

`ifdef MEM_MISALIGN_CHK_EN
  logic [1:0] cur_sz;
  assign cur_sz       = size_of(MEM_funct3);
  assign misalign_hit = access & (((cur_sz == 2'd1) & MEM_ALU_out[0]) |
                                  ((cur_sz == 2'd2) & (|MEM_ALU_out[1:0])));
`else
  assign misalign_hit = 1'b0;
`endif

  // Same-cycle stall in IDLE so the instruction never slips past MEM before the request is latched.
  assign mem_stall    = busy | ((state == IDLE) & access & ~misalign_hit);
  assign mem_misalign = (state == IDLE) & misalign_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      req     <= '0;
      req_vld <= 1'b0;
      busy    <= 1'b0;
      DM_data <= '0;
    end else begin
      case (state)
        IDLE: if (access && !misalign_hit) begin
          req.we     <= ~MEM_mem_rd;
          req.funct3 <= MEM_funct3;
          req.addr   <= MEM_ALU_out;
          req.data   <= MEM_rs2_data;
          req_vld    <= 1'b1;
          busy       <= 1'b1;
          state      <= REQ;
        end
        REQ: if (dm_req_ready) begin
          req_vld <= 1'b0;
          state   <= RESP;
        end
        RESP: if (dm_rsp_valid) begin
          if (!req.we) DM_data <= ld_ext;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dm_req_valid = req_vld;
  assign dm_req_we    = req.we;
  assign dm_req_addr  = {req.addr[ADDR_W-1:2], 2'b00};
  assign req_sz       = size_of(req.funct3);

  logic [NUM_LANES-1:0]      lane_strb;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mau_store_lane #(.LANE(i)) u_lane (
      .sz      (req_sz),
      .addr_lo (req.addr[1:0]),
      .byte_b  (req.data[7:0]),
      .byte_h  (req.data[8*(i%2) +: 8]),
      .byte_w  (req.data[8*i +: 8]),
      .strb    (lane_strb[i]),
      .wdata   (lane_wdata[i])
    );
  end

  assign dm_req_wstrb = req.we ? lane_strb : '0;
  assign dm_req_wdata = lane_wdata;

  assign ld_byte = dm_rsp_rdata[{req.addr[1:0], 3'b000} +: 8];
  assign ld_half = dm_rsp_rdata[{req.addr[1], 4'b0000} +: 16];

  always_comb begin
    case (req.funct3)
      3'b000:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_ext = dm_rsp_rdata;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors plus reset, stray-response and misalign sequences.

module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        MEM_valid, MEM_mem_rd, MEM_mem_wr;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_ALU_out, MEM_rs2_data;
  logic        dm_req_valid, dm_req_ready, dm_req_we;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic [3:0]  dm_req_wstrb;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_rdata, DM_data;
  logic        mem_stall, mem_misalign;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .MEM_valid(MEM_valid), .MEM_mem_rd(MEM_mem_rd), .MEM_mem_wr(MEM_mem_wr),
    .MEM_funct3(MEM_funct3), .MEM_ALU_out(MEM_ALU_out), .MEM_rs2_data(MEM_rs2_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_req_addr(dm_req_addr), .dm_req_wstrb(dm_req_wstrb), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
    .DM_data(DM_data), .mem_stall(mem_stall), .mem_misalign(mem_misalign)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          rdy_dly, rsp_dly;
    logic        stray;
    logic        we;
    logic [31:0] eaddr;
    logic [3:0]  strb;
    logic [31:0] wdata, dm;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_dm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_req(input string tag, input vec_t v);
    check({tag, "_req_valid"}, 32'(dm_req_valid), 32'd1);
    check({tag, "_stall"}, 32'(mem_stall), 32'd1);
    check({tag, "_we"}, 32'(dm_req_we), 32'(v.we));
    check({tag, "_addr"}, dm_req_addr, v.eaddr);
    check({tag, "_strb"}, 32'(dm_req_wstrb), 32'(v.strb));
    if (v.we) check({tag, "_wdata"}, dm_req_wdata, v.wdata);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    logic [31:0] exp_dm;
    t = $sformatf("v%0d", idx);
    MEM_valid = 1'b1; MEM_mem_rd = v.rd; MEM_mem_wr = v.wr;
    MEM_funct3 = v.f3; MEM_ALU_out = v.addr; MEM_rs2_data = v.rs2;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
    @(negedge clk);
    check({t, "_idle_stall"}, 32'(mem_stall), 32'd1);
    check({t, "_idle_req_valid"}, 32'(dm_req_valid), 32'd0);
    check({t, "_misalign"}, 32'(mem_misalign), 32'd0);
    @(posedge clk); #1;
    for (int n = 0; n < v.rdy_dly; n++) begin
      if (v.stray) begin dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h0BAD0BAD; end
      @(negedge clk);
      chk_req($sformatf("%s_wait%0d", t, n), v);
      @(posedge clk); #1;
    end
    dm_rsp_valid = 1'b0;
    dm_req_ready = 1'b1;
    @(negedge clk);
    chk_req({t, "_hs"}, v);
    @(posedge clk); #1;
    dm_req_ready = 1'b0;
    for (int n = 0; n < v.rsp_dly; n++) begin
      @(negedge clk);
      check($sformatf("%s_resp_wait%0d_stall", t, n), 32'(mem_stall), 32'd1);
      check($sformatf("%s_resp_wait%0d_valid", t, n), 32'(dm_req_valid), 32'd0);
      @(posedge clk); #1;
    end
    dm_rsp_valid = 1'b1; dm_rsp_rdata = v.rdata;
    @(negedge clk);
    check({t, "_resp_stall"}, 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    dm_rsp_valid = 1'b0; MEM_valid = 1'b0;
    exp_dm = v.we ? last_dm : v.dm;
    last_dm = exp_dm;
    @(negedge clk);
    check({t, "_done_stall"}, 32'(mem_stall), 32'd0);
    check({t, "_dm_data"}, DM_data, exp_dm);
    @(posedge clk); #1;
  endtask

  initial begin
    //                rd wr f3      addr          rs2           rdata        rdy rsp st  we eaddr         strb     wdata         dm
    vecs.push_back('{1, 0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 32'h104, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1, 0, 3'b000, 32'h203, 32'h0,        32'h80FF0011, 0, 0, 0, 0, 32'h200, 4'b0000, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{1, 0, 3'b100, 32'h203, 32'h0,        32'h80FF0011, 0, 0, 0, 0, 32'h200, 4'b0000, 32'h0,        32'h00000080});
    vecs.push_back('{1, 0, 3'b101, 32'h202, 32'h0,        32'h80FF0011, 0, 0, 0, 0, 32'h200, 4'b0000, 32'h0,        32'h000080FF});
    vecs.push_back('{1, 0, 3'b001, 32'h202, 32'h0,        32'h80FF0011, 0, 0, 0, 0, 32'h200, 4'b0000, 32'h0,        32'hFFFF80FF});
    vecs.push_back('{1, 0, 3'b001, 32'h200, 32'h0,        32'h80FF0011, 2, 1, 0, 0, 32'h200, 4'b0000, 32'h0,        32'h00000011});
    vecs.push_back('{1, 0, 3'b000, 32'h202, 32'h0,        32'h80FF0011, 0, 0, 0, 0, 32'h200, 4'b0000, 32'h0,        32'hFFFFFFFF});
    vecs.push_back('{1, 0, 3'b100, 32'h200, 32'h0,        32'h80FF0011, 0, 0, 0, 0, 32'h200, 4'b0000, 32'h0,        32'h00000011});
    vecs.push_back('{0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h300, 4'b1100, 32'hABCDABCD, 32'h0});
    vecs.push_back('{0, 1, 3'b000, 32'h301, 32'h1234ABCD, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h300, 4'b0010, 32'hCDCDCDCD, 32'h0});
    vecs.push_back('{0, 1, 3'b010, 32'h308, 32'h1234ABCD, 32'hFFFFFFFF, 5, 0, 1, 1, 32'h308, 4'b1111, 32'h1234ABCD, 32'h0});
    vecs.push_back('{0, 1, 3'b001, 32'h300, 32'h1234ABCD, 32'hFFFFFFFF, 0, 2, 0, 1, 32'h300, 4'b0011, 32'hABCDABCD, 32'h0});
    vecs.push_back('{1, 1, 3'b010, 32'h400, 32'h0,        32'h55AA55AA, 0, 0, 0, 0, 32'h400, 4'b0000, 32'h0,        32'h55AA55AA});
    vecs.push_back('{1, 0, 3'b011, 32'h404, 32'h0,        32'hCAFEF00D, 0, 0, 0, 0, 32'h404, 4'b0000, 32'h0,        32'hCAFEF00D});
    vecs.push_back('{1, 0, 3'b000, 32'h201, 32'h0,        32'h80FF0011, 1, 0, 1, 0, 32'h200, 4'b0000, 32'h0,        32'h00000000});
`ifndef MEM_MISALIGN_CHK_EN
    vecs.push_back('{1, 0, 3'b010, 32'h101, 32'h0,        32'h13579BDF, 0, 0, 0, 0, 32'h100, 4'b0000, 32'h0,        32'h13579BDF});
    vecs.push_back('{1, 0, 3'b001, 32'h203, 32'h0,        32'h80FF0011, 0, 0, 0, 0, 32'h200, 4'b0000, 32'h0,        32'hFFFF80FF});
    vecs.push_back('{0, 1, 3'b000, 32'h303, 32'h000000A5, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h300, 4'b1000, 32'hA5A5A5A5, 32'h0});
    vecs.push_back('{0, 1, 3'b010, 32'h30A, 32'h87654321, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h308, 4'b1111, 32'h87654321, 32'h0});
`endif

    rstn = 1'b0; MEM_valid = 1'b0; MEM_mem_rd = 1'b0; MEM_mem_wr = 1'b0;
    MEM_funct3 = 3'b0; MEM_ALU_out = '0; MEM_rs2_data = '0;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_rdata = '0;
    last_dm = '0;
    repeat (2) @(negedge clk);
    check("rst_dm_data", DM_data, 32'h0);
    check("rst_req_valid", 32'(dm_req_valid), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_misalign", 32'(mem_misalign), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // stray responses while idle must not touch DM_data
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h0BADF00D;
    repeat (2) begin
      @(negedge clk);
      check("stray_idle_dm", DM_data, last_dm);
      check("stray_idle_stall", 32'(mem_stall), 32'd0);
      check("stray_idle_req_valid", 32'(dm_req_valid), 32'd0);
    end
    @(posedge clk); #1;
    dm_rsp_valid = 1'b0;

`ifdef MEM_MISALIGN_CHK_EN
    MEM_valid = 1'b1; MEM_mem_rd = 1'b1; MEM_mem_wr = 1'b0;
    MEM_funct3 = 3'b010; MEM_ALU_out = 32'h101;
    @(negedge clk);
    check("mis_pulse", 32'(mem_misalign), 32'd1);
    check("mis_stall", 32'(mem_stall), 32'd0);
    check("mis_req_valid", 32'(dm_req_valid), 32'd0);
    @(posedge clk); #1;
    MEM_valid = 1'b0;
    @(negedge clk);
    check("mis_pulse_end", 32'(mem_misalign), 32'd0);
    check("mis_no_req", 32'(dm_req_valid), 32'd0);
    check("mis_dm_data", DM_data, last_dm);
    @(posedge clk); #1;
`endif

    // reset while waiting in RESP; the late response must be dropped
    MEM_valid = 1'b1; MEM_mem_rd = 1'b1; MEM_mem_wr = 1'b0;
    MEM_funct3 = 3'b010; MEM_ALU_out = 32'h500;
    @(posedge clk); #1;
    dm_req_ready = 1'b1;
    @(posedge clk); #1;
    dm_req_ready = 1'b0;
    @(negedge clk);
    check("rr_resp_stall", 32'(mem_stall), 32'd1);
    rstn = 1'b0;
    MEM_valid = 1'b0;
    #1;
    check("rr_stall", 32'(mem_stall), 32'd0);
    check("rr_req_valid", 32'(dm_req_valid), 32'd0);
    check("rr_dm_data", DM_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    check("rr_late_dm", DM_data, 32'h0);
    check("rr_late_stall", 32'(mem_stall), 32'd0);
    check("rr_late_req_valid", 32'(dm_req_valid), 32'd0);
    dm_rsp_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
